// File: rtl/vgg_pkg.sv
// Shared definitions for the VGG conv/pool stages: pixel width, the layer-2
// feature-map geometry and the signed pixel type.
package vgg_pkg;

   localparam int DATA_W   = 16;
   localparam int L2_IMG_W = 224;
   localparam int L2_IMG_H = 224;

   typedef logic signed [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/maxpool_layer2_line_buffer.sv
// Single-row store of horizontal maxima from even rows of the input stream.
// Synchronous write, combinational read, storage deliberately left unreset.
module pool_line_buffer #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 112,
   parameter int AW     = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_layer2.sv
// 2x2 / stride-2 streaming max-pool. Position is derived purely from the count
// of valid pixels; the producer is never stalled.
module maxpool_layer2 #(
   parameter int DATA_W = vgg_pkg::DATA_W,
   parameter int IMG_W  = vgg_pkg::L2_IMG_W,
   parameter int IMG_H  = vgg_pkg::L2_IMG_H
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic signed [DATA_W-1:0] data_in,
   output logic                     valid_out,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int AW = CW - 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic signed [DATA_W-1:0] h_reg;
   logic signed [DATA_W-1:0] hmax;
   logic signed [DATA_W-1:0] vmax;
   logic signed [DATA_W-1:0] lb_rdata;
   logic                     lb_we;
   logic                     col_last;
   logic                     row_last;

   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);

   // Both compares are full-width signed; a tie simply passes the equal value.
   assign hmax  = (data_in > h_reg) ? data_in : h_reg;
   assign vmax  = (lb_rdata > hmax) ? lb_rdata : hmax;
   assign lb_we = valid_in & col[0] & ~row[0];

   // Write and read happen in rows of opposite parity, so they never collide.
   pool_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W / 2),
      .AW     (AW)
   ) u_line_buffer (
      .clk   (clk),
      .we    (lb_we),
      .waddr (col[CW-1:1]),
      .wdata (hmax),
      .raddr (col[CW-1:1]),
      .rdata (lb_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         h_reg      <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (valid_in) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end

            if (!col[0]) begin
               h_reg <= data_in;
            end else if (row[0]) begin
               data_out   <= vmax;
               valid_out  <= 1'b1;
               frame_done <= col_last & row_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool_layer2.sv
// Directed bench for maxpool_layer2: 4x4 vector tables, a mid-frame reset
// sequence, and a full 224x224 random frame against a reference model.
module tb_maxpool_layer2;

   localparam int DW = 16;
   localparam int BW = 224;
   localparam int BH = 224;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                 valid_in;
   logic signed [DW-1:0] data_in;
   logic                 valid_out;
   logic signed [DW-1:0] data_out;
   logic                 frame_done;

   logic                 big_valid;
   logic signed [DW-1:0] big_data;
   logic                 big_vout;
   logic signed [DW-1:0] big_dout;
   logic                 big_done;

   maxpool_layer2 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .frame_done (frame_done)
   );

   maxpool_layer2 #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BH)) dut_big (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (big_valid),
      .data_in    (big_data),
      .valid_out  (big_vout),
      .data_out   (big_dout),
      .frame_done (big_done)
   );

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;
   int held  = 0;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit vin;
      int din;
      bit ev;
      int ed;
      bit ef;
   } vec_t;

   vec_t vecs[$];

   task automatic push(input bit vin, input int din, input bit ev, input int ed, input bit ef);
      vec_t v;
      v.vin = vin; v.din = din; v.ev = ev; v.ed = ed; v.ef = ef;
      vecs.push_back(v);
   endtask

   function automatic bit is_br(input int i);
      return (i == 5) || (i == 7) || (i == 13) || (i == 15);
   endfunction

   // Ascending ramp: each window's max is its bottom-right pixel.
   task automatic push_ramp(input int base);
      for (int i = 0; i < 16; i++)
         push(1'b1, base + i, is_br(i), base + i, i == 15);
   endtask

   // Called at a falling edge; each record's expectations describe the
   // outputs one cycle after its input is applied.
   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         valid_in = vecs[i].vin;
         data_in  = DW'(vecs[i].din);
         @(negedge clk);
         if (vecs[i].ev) held = vecs[i].ed;
         check($sformatf("%s[%0d] valid_out", tag, i), valid_out, vecs[i].ev);
         check($sformatf("%s[%0d] data_out", tag, i), $signed(data_out), held);
         check($sformatf("%s[%0d] frame_done", tag, i), frame_done, vecs[i].ef);
      end
      vecs.delete();
      valid_in = 1'b0;
      data_in  = '0;
   endtask

   // ---------------- big-frame scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   logic signed [DW-1:0] img [BW*BH];
   bit big_on = 1'b0;
   int big_cnt = 0;
   int big_done_cnt = 0;
   int big_done_ok = 0;

   always @(negedge clk) begin
      if (big_on) begin
         if (big_vout) begin
            big_cnt++;
            if (exp_q.size() == 0) begin
               check("big unexpected output", 1, 0);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               check($sformatf("big out %0d", big_cnt - 1), $signed(big_dout), $signed(e));
               if (big_done && exp_q.size() == 0) big_done_ok++;
            end
         end
         if (big_done) big_done_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int neg [16];
      int neg_exp [16];
      bit [15:0] gap_mask;

      rst       = 1'b1;
      valid_in  = 1'b0;
      data_in   = '0;
      big_valid = 1'b0;
      big_data  = '0;
      repeat (3) @(negedge clk);
      check("reset valid_out", valid_out, 0);
      check("reset data_out", $signed(data_out), 0);
      check("reset frame_done", frame_done, 0);
      rst  = 1'b0;
      held = 0;

      // Ramp 0..15 with continuous valid.
      push_ramp(0);
      push(1'b0, 0, 1'b0, 0, 1'b0);
      run_vecs("ramp");

      // Signed windows: {-3,-8,-1,-20} -> -1, four -32768 -> -32768,
      // {1,2,-9,9} -> 9, {3,4,-7,0} -> 4.
      neg = '{-3, -8, -32768, -32768,
              -1, -20, -32768, -32768,
               1,   2,      3,      4,
              -9,   9,     -7,      0};
      neg_exp = '{0, 0, 0, 0, 0, -1, 0, -32768, 0, 0, 0, 0, 0, 9, 0, 4};
      for (int i = 0; i < 16; i++)
         push(1'b1, neg[i], is_br(i), neg_exp[i], i == 15);
      push(1'b0, 0, 1'b0, 0, 1'b0);
      run_vecs("neg");

      // Ramp with single idle cycles carrying junk data.
      gap_mask = 16'b0101_0001_0010_1001;
      for (int i = 0; i < 16; i++) begin
         push(1'b1, i, is_br(i), i, i == 15);
         if (gap_mask[i]) push(1'b0, 999, 1'b0, 0, 1'b0);
      end
      push(1'b0, -999, 1'b0, 0, 1'b0);
      run_vecs("gaps");

      // Two frames back to back; the second must not depend on the first.
      push_ramp(100);
      push_ramp(0);
      push(1'b0, 0, 1'b0, 0, 1'b0);
      run_vecs("b2b");

      // Partial frame, then reset mid-frame.
      for (int i = 0; i < 6; i++)
         push(1'b1, 50 + i, i == 5, 55, 1'b0);
      run_vecs("abort");
      rst = 1'b1;
      #2;
      check("async rst valid_out", valid_out, 0);
      check("async rst data_out", $signed(data_out), 0);
      check("async rst frame_done", frame_done, 0);
      valid_in = 1'b1;
      data_in  = 16'sd77;
      @(negedge clk);
      check("held rst valid_out", valid_out, 0);
      check("held rst data_out", $signed(data_out), 0);
      check("held rst frame_done", frame_done, 0);
      valid_in = 1'b0;
      rst      = 1'b0;
      held     = 0;
      push_ramp(0);
      push(1'b0, 0, 1'b0, 0, 1'b0);
      push(1'b0, 0, 1'b0, 0, 1'b0);
      run_vecs("post_rst");

      // Full-size random frame against a reference max-pool.
      for (int p = 0; p < BW * BH; p++) img[p] = DW'($urandom_range(0, 65535));
      for (int r = 0; r < BH / 2; r++) begin
         for (int c = 0; c < BW / 2; c++) begin
            logic signed [DW-1:0] m;
            m = img[(2*r) * BW + 2*c];
            if (img[(2*r) * BW + 2*c + 1] > m) m = img[(2*r) * BW + 2*c + 1];
            if (img[(2*r + 1) * BW + 2*c] > m) m = img[(2*r + 1) * BW + 2*c];
            if (img[(2*r + 1) * BW + 2*c + 1] > m) m = img[(2*r + 1) * BW + 2*c + 1];
            exp_q.push_back(m);
         end
      end
      big_on = 1'b1;
      for (int p = 0; p < BW * BH; p++) begin
         big_valid = 1'b1;
         big_data  = img[p];
         @(negedge clk);
      end
      big_valid = 1'b0;
      repeat (4) @(negedge clk);
      big_on = 1'b0;
      check("big output count", big_cnt, (BW / 2) * (BH / 2));
      check("big leftover expected", exp_q.size(), 0);
      check("big frame_done count", big_done_cnt, 1);
      check("big frame_done on last", big_done_ok, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
